// File: rtl/b13_rx.sv
// b13_rx: strobe-based serial receiver. A low sample in IDLE starts a frame. Eight data
// strobes follow, BIT_PERIOD clocks apart, and are shifted in MSB first. A final stop
// strobe completes the frame and the received byte is held until the consumer acks it.
// Optional feature macro: B13_RX_DSR_EN (registered ready-to-receive on dsr);
// otherwise dsr is tied high.
//
// Ports:
//   clock       - single clock, rising edge
//   reset       - synchronous, active-high
//   serial_in   - line input, idle high, one-clock strobes
//   rd_ack      - consumer acknowledge, clears rx_valid
//   rx_data     - last correctly framed byte
//   rx_valid    - rx_data holds an unacknowledged byte
//   frame_error - one-clock pulse when the stop strobe is low
//   overrun     - one-clock pulse when a byte lands on an unacked byte
//   busy        - frame in progress
//   dsr         - ready-to-receive indication
module b13_rx #(
  parameter int unsigned BIT_PERIOD = 106
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy,
  output logic       dsr
);

  localparam logic [6:0] LastCnt = 7'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e     state_q, state_d;
  logic [6:0] period_q, period_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       busy_q, busy_d;
  logic       strobe;

  assign strobe = (period_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    busy_d   = busy_q;

    if (rd_ack && valid_q) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!serial_in) begin
          state_d  = StData;
          period_d = '0;
          bit_d    = '0;
          busy_d   = 1'b1;
        end
      end
      StData: begin
        if (strobe) begin
          period_d = '0;
          shift_d  = {shift_q[6:0], serial_in};
          bit_d    = bit_q + 3'd1;  // wraps 7->0 as we enter STOP
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          period_d = period_q + 7'd1;
        end
      end
      StStop: begin
        if (strobe) begin
          period_d = '0;
          state_d  = StIdle;
          busy_d   = 1'b0;
          if (serial_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // An ack on this same edge frees the slot, so it is not an overrun.
            ovr_d   = valid_q && !rd_ack;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          period_d = period_q + 7'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      period_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

`ifdef B13_RX_DSR_EN
  logic dsr_q, dsr_d;

  // Built from next-state values so an ack or a return to IDLE shows on the same edge.
  always_comb begin
    dsr_d = (state_d == StIdle) && !valid_d;
  end

  always_ff @(posedge clock) begin
    if (reset) dsr_q <= 1'b1;
    else       dsr_q <= dsr_d;
  end

  assign dsr = dsr_q;
`else
  assign dsr = 1'b1;
`endif

endmodule

// File: tb/tb_b13_rx.sv
// tb_b13_rx: bench for b13_rx. Hand-written sequences cover reset, exact stop timing,
// frame error and mid-frame reset. A vector table of back-to-back frames feeds a
// scoreboard that is checked whenever the DUT finishes a frame.
module tb_b13_rx;

  localparam int unsigned Bp = 106;
`ifdef B13_RX_DSR_EN
  localparam bit DsrEn = 1'b1;
`else
  localparam bit DsrEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic       dsr;

  b13_rx #(.BIT_PERIOD(Bp)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .rd_ack      (rd_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy),
    .dsr         (dsr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pre_ack;
    logic       stop_ack;
    logic       glitch;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en = 1'b0;
  logic busy_prev = 1'b0;
  logic pre_stop_valid, pre_stop_busy, pre_stop_dsr, post_start_busy, post_start_dsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start strobe, eight data strobes (MSB first), then the stop strobe. Returns just
  // after the stop edge. Optional pre_ack rides on the start edge, stop_ack on the stop edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pre_ack,
                            input logic stop_ack, input logic glitch);
    serial_in = 1'b0;
    rd_ack    = pre_ack;
    tick();
    serial_in = 1'b1;
    rd_ack    = 1'b0;
    post_start_busy = busy;
    post_start_dsr  = dsr;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < int'(Bp) - 1; j++) begin
        serial_in = (glitch && i == 3 && j == int'(Bp) / 2) ? 1'b0 : 1'b1;
        tick();
      end
      serial_in = d[7-i];
      tick();
      serial_in = 1'b1;
    end
    repeat (Bp - 1) tick();
    pre_stop_valid = rx_valid;
    pre_stop_busy  = busy;
    pre_stop_dsr   = dsr;
    serial_in = stop;
    rd_ack    = stop_ack;
    tick();
    serial_in = 1'b1;
    rd_ack    = 1'b0;
  endtask

  // Scoreboard side: a busy fall marks a finished frame.
  always @(negedge clock) begin
    busy_prev <= busy;
    if (mon_en && busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("sb_rx_data", 32'(rx_data), 32'(e.e_data));
        check("sb_rx_valid", 32'(rx_valid), 32'(e.e_valid));
        check("sb_frame_error", 32'(frame_error), 32'(e.e_ferr));
        check("sb_overrun", 32'(overrun), 32'(e.e_ovr));
        check("sb_dsr", 32'(dsr), DsrEn ? 32'(!e.e_valid) : 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           data   stop  pre   sack  glch  e_data e_v   e_fe  e_ov
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, 1'b1};

    reset     = 1'b1;
    serial_in = 1'b1;
    rd_ack    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dsr", 32'(dsr), 32'd1);

    // Frame 0xA5: valid must appear exactly on the stop edge, not one earlier.
    repeat (6) tick();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a5_busy_after_start", 32'(post_start_busy), 32'd1);
    check("a5_dsr_after_start", 32'(post_start_dsr), DsrEn ? 32'd0 : 32'd1);
    check("a5_valid_before_stop", 32'(pre_stop_valid), 32'd0);
    check("a5_busy_before_stop", 32'(pre_stop_busy), 32'd1);
    check("a5_dsr_before_stop", 32'(pre_stop_dsr), DsrEn ? 32'd0 : 32'd1);
    check("a5_rx_data", 32'(rx_data), 32'hA5);
    check("a5_rx_valid", 32'(rx_valid), 32'd1);
    check("a5_busy_after_stop", 32'(busy), 32'd0);
    check("a5_dsr_unacked", 32'(dsr), DsrEn ? 32'd0 : 32'd1);
    repeat (5) tick();
    check("a5_busy_idle", 32'(busy), 32'd0);
    check("a5_valid_held", 32'(rx_valid), 32'd1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("a5_valid_acked", 32'(rx_valid), 32'd0);
    check("a5_dsr_acked", 32'(dsr), 32'd1);

    // Get a byte pending, then reset around bit 4 of 0xFF with rd_ack and a low line.
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    repeat (4 * Bp + Bp / 2) tick();
    check("ff_busy_mid", 32'(busy), 32'd1);
    reset     = 1'b1;
    rd_ack    = 1'b1;
    serial_in = 1'b0;
    tick();
    reset     = 1'b0;
    rd_ack    = 1'b0;
    serial_in = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_dsr", 32'(dsr), 32'd1);
    tick();
    check("midrst_no_start", 32'(busy), 32'd0);

    // Frame error on 0x3C, then a new frame started 106 clocks after the stop strobe.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", 32'(frame_error), 32'd1);
    check("ferr_rx_valid", 32'(rx_valid), 32'd0);
    check("ferr_rx_data", 32'(rx_data), 32'h00);
    check("ferr_busy", 32'(busy), 32'd0);
    tick();
    check("ferr_one_clock", 32'(frame_error), 32'd0);
    check("ferr_not_start", 32'(busy), 32'd0);
    repeat (Bp - 2) tick();
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check("r81_busy_after_start", 32'(post_start_busy), 32'd1);
    check("r81_rx_data", 32'(rx_data), 32'h81);
    check("r81_rx_valid", 32'(rx_valid), 32'd1);
    tick();
    check("r81_overrun_low", 32'(overrun), 32'd0);

    // Back-to-back table frames, each start on the edge right after the previous stop.
    mon_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vecs[v]);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].pre_ack, vecs[v].stop_ack,
                 vecs[v].glitch);
    end
    tick();
    check("ovr_one_clock", 32'(overrun), 32'd0);
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b13_rx.md
B13_RX -- requirements
Module: b13_rx

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 106, the number of clocks between successive bit strobes on the serial line.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port serial_in, input, 1 bit: transmit line; idle high, each frame element is a one-clock strobe.
REQ-005 SHALL have port rd_ack, input, 1 bit: consumer acknowledge; clears rx_valid.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly framed byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: rx_data holds an unacknowledged byte.
REQ-008 SHALL have port frame_error, output, 1 bit: one-clock pulse when the stop strobe is low.
REQ-009 SHALL have port overrun, output, 1 bit: one-clock pulse when a byte completes while rx_valid is set and not acked.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port dsr, output, 1 bit: ready-to-receive indication to the transmitter.

Function
REQ-012 SHALL implement states IDLE, DATA, STOP; all outputs registered.
REQ-013 In IDLE, serial_in sampled 0 at edge k SHALL move to DATA, clear the bit counter to 0 and the period counter to 0, and set busy.
REQ-014 Data bit i (i = 0..7) SHALL be sampled at edge k+(i+1)*BIT_PERIOD; bit 0 goes to rx_data[7] (MSB first), bit 7 to rx_data[0].
REQ-015 Serial_in between strobes SHALL be ignored.
REQ-016 After bit 7, SHALL enter STOP; the stop strobe SHALL be sampled at edge k+9*BIT_PERIOD.
REQ-017 Stop sampled 1: the shifted byte SHALL be loaded into rx_data and rx_valid set, both visible after that edge; the state SHALL return to IDLE and busy clear.
REQ-018 Stop sampled 0: frame_error SHALL pulse for one clock and rx_data/rx_valid SHALL be unchanged; the state SHALL return to IDLE; that low SHALL NOT count as a new start.
REQ-019 In IDLE, a new start SHALL be accepted on the edge immediately after the return to IDLE.
REQ-020 rd_ack high while rx_valid is set SHALL clear rx_valid on that edge; rd_ack with rx_valid clear SHALL have no effect.
REQ-021 On a completing stop with rx_valid set, overrun SHALL pulse and the new byte SHALL overwrite rx_data; if rd_ack is high on that same edge, the new byte SHALL load, rx_valid SHALL stay set, and overrun SHALL stay low.
REQ-022 The period counter SHALL be 7 bits, count 0..BIT_PERIOD-1, and wrap to 0 at each strobe.
REQ-023 The bit counter SHALL be 3 bits and SHALL wrap 7->0 on entering STOP.

Reset
REQ-024 Reset SHALL force IDLE, counters 0, rx_data 0x00, rx_valid 0, frame_error 0, overrun 0, busy 0, dsr 1 (with the Configuration macro) or 1 (tied), from any state including mid-frame.
REQ-025 Reset SHALL take priority over rd_ack and serial_in on the same edge.

Configuration
REQ-026 With B13_RX_DSR_EN defined, dsr SHALL be registered high only when the state is IDLE and rx_valid is 0 (or is being cleared by rd_ack).
REQ-027 Without B13_RX_DSR_EN, dsr SHALL be constant 1 and no dsr logic SHALL be generated.

Verification
REQ-028 Scenario: reset, then frame 0xA5 (start low at edge 10, strobes every 106 edges, stop 1) -> rx_data=0xA5, rx_valid=1 after edge 964; busy low thereafter.
REQ-029 Scenario: frame 0x3C with stop strobe 0 -> frame_error is a one-clock pulse at edge k+954, rx_valid stays 0, and the next low strobe 106 clocks later starts a new frame.
REQ-030 Scenario: two back-to-back frames 0x01 then 0xFE with no rd_ack -> overrun pulses at the second stop and rx_data=0xFE; repeat with rd_ack on that edge -> no overrun, rx_valid=1.
REQ-031 Scenario: reset asserted at bit 4 of frame 0xFF -> next edge shows IDLE, busy=0, rx_valid=0, rx_data=0x00; a following 0x81 frame is received correctly.
REQ-032 Scenario: B13_RX_DSR_EN defined, frame 0x55 received, rd_ack held low -> dsr 0 from start strobe until rd_ack; then dsr=1; undefined build -> dsr=1 throughout.
REQ-033 Scenario: glitch-free low pulse between strobes mid-frame on 0x00 -> ignored; rx_data=0x00 with rx_valid=1.
